// File: rtl/ssh_banner_classify.sv
// ssh_banner_classify: per-flow "SSH-" banner labeller with 2-stage pipeline; SSH_VER_CHECK_EN also requires "2.0-"
module ssh_banner_classify #(
  parameter int         DATA_W       = 64,
  parameter int         FLOW_ID_W    = 8,
  parameter logic [5:0] MATCH_CYCLE  = 6'd1,
  parameter logic [2:0] DECIDE_PKT   = 3'd4,
  parameter logic [5:0] DECIDE_CYCLE = 6'd32,
  parameter logic [2:0] TYPE_CODE    = 3'b100
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_pkt_data_valid,
  input  logic [DATA_W-1:0]    i_pkt_data,
  input  logic [7:0]           i_pkt_len,
  input  logic [2:0]           i_pkt_num,
  input  logic [7:0]           i_pkt_protocol,
  input  logic [5:0]           i_pkt_cycle_cnt,
  input  logic [FLOW_ID_W-1:0] i_flow_id,
  input  logic                 i_flow_clr,
  input  logic [FLOW_ID_W-1:0] i_flow_clr_id,
  output logic                 o_pkt_data_valid,
  output logic [DATA_W-1:0]    o_pkt_data,
  output logic [7:0]           o_pkt_len,
  output logic [2:0]           o_pkt_num,
  output logic [7:0]           o_pkt_protocol,
  output logic [5:0]           o_pkt_cycle_cnt,
  output logic [FLOW_ID_W-1:0] o_flow_id,
  output logic [2:0]           o_flow_type,
  output logic                 o_decide,
  output logic [15:0]          o_match_cnt
);
  localparam int DEPTH = 1 << FLOW_ID_W;
`ifdef SSH_VER_CHECK_EN
  localparam int MIN_W = 64;
`else
  localparam int MIN_W = 32;
`endif
  if (DATA_W < MIN_W) begin : g_bad_width
    $error("ssh_banner_classify: DATA_W too small for the enabled banner check");
  end
  logic                 r1_valid_q, r1_valid_d;
  logic [DATA_W-1:0]    r1_data_q, r1_data_d;
  logic [7:0]           r1_len_q, r1_len_d;
  logic [2:0]           r1_num_q, r1_num_d;
  logic [7:0]           r1_proto_q, r1_proto_d;
  logic [5:0]           r1_cyc_q, r1_cyc_d;
  logic [FLOW_ID_W-1:0] r1_fid_q, r1_fid_d;
  logic                 o_valid_q, o_valid_d;
  logic [DATA_W-1:0]    o_data_q, o_data_d;
  logic [7:0]           o_len_q, o_len_d;
  logic [2:0]           o_num_q, o_num_d;
  logic [7:0]           o_proto_q, o_proto_d;
  logic [5:0]           o_cyc_q, o_cyc_d;
  logic [FLOW_ID_W-1:0] o_fid_q, o_fid_d;
  logic [2:0]           o_type_q, o_type_d;
  logic                 o_dec_q, o_dec_d;
  logic [15:0]          cnt_q, cnt_d;
  logic [2:0]           type_q [DEPTH];
  logic [2:0]           type_d [DEPTH];
  logic                 lock_q [DEPTH];
  logic                 lock_d [DEPTH];
  logic [2:0]           entry_type, s2_type;
  logic                 entry_lock, banner, match, decide;
  always_comb begin
    r1_valid_d = i_pkt_data_valid;
    r1_data_d  = i_pkt_data;
    r1_len_d   = i_pkt_len;
    r1_num_d   = i_pkt_num;
    r1_proto_d = i_pkt_protocol;
    r1_cyc_d   = i_pkt_cycle_cnt;
    r1_fid_d   = i_flow_id;
    entry_type = type_q[r1_fid_q];
    entry_lock = lock_q[r1_fid_q];
`ifdef SSH_VER_CHECK_EN
    banner = r1_data_q[31:0] == 32'h2d485353 && r1_data_q[63:32] == 32'h2d302e32;
`else
    banner = r1_data_q[31:0] == 32'h2d485353;
`endif
    match  = r1_valid_q && r1_proto_q == 8'h06 && r1_cyc_q == MATCH_CYCLE && banner && !entry_lock;
    decide = r1_valid_q && r1_num_q == DECIDE_PKT && r1_cyc_q == DECIDE_CYCLE;
    s2_type = match ? TYPE_CODE : entry_type;
    cnt_d = (match && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
    o_valid_d = r1_valid_q;
    o_data_d  = r1_data_q;
    o_len_d   = r1_len_q;
    o_num_d   = r1_num_q;
    o_proto_d = r1_proto_q;
    o_cyc_d   = r1_cyc_q;
    o_fid_d   = r1_fid_q;
    o_type_d  = s2_type;
    o_dec_d   = decide;
    type_d = type_q;
    lock_d = lock_q;
    if (i_flow_clr) begin
      type_d[i_flow_clr_id] = 3'b000;
      lock_d[i_flow_clr_id] = 1'b0;
    end
    // applied after the clear so a same-ID stage-2 write takes priority
    if (match || decide) begin
      type_d[r1_fid_q] = s2_type;
      lock_d[r1_fid_q] = entry_lock || decide;
    end
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r1_valid_q <= 1'b0;
      r1_data_q  <= '0;
      r1_len_q   <= '0;
      r1_num_q   <= '0;
      r1_proto_q <= '0;
      r1_cyc_q   <= '0;
      r1_fid_q   <= '0;
      o_valid_q  <= 1'b0;
      o_data_q   <= '0;
      o_len_q    <= '0;
      o_num_q    <= '0;
      o_proto_q  <= '0;
      o_cyc_q    <= '0;
      o_fid_q    <= '0;
      o_type_q   <= '0;
      o_dec_q    <= 1'b0;
      cnt_q      <= '0;
      type_q     <= '{default: '0};
      lock_q     <= '{default: '0};
    end else begin
      r1_valid_q <= r1_valid_d;
      r1_data_q  <= r1_data_d;
      r1_len_q   <= r1_len_d;
      r1_num_q   <= r1_num_d;
      r1_proto_q <= r1_proto_d;
      r1_cyc_q   <= r1_cyc_d;
      r1_fid_q   <= r1_fid_d;
      o_valid_q  <= o_valid_d;
      o_data_q   <= o_data_d;
      o_len_q    <= o_len_d;
      o_num_q    <= o_num_d;
      o_proto_q  <= o_proto_d;
      o_cyc_q    <= o_cyc_d;
      o_fid_q    <= o_fid_d;
      o_type_q   <= o_type_d;
      o_dec_q    <= o_dec_d;
      cnt_q      <= cnt_d;
      type_q     <= type_d;
      lock_q     <= lock_d;
    end
  end
  assign o_pkt_data_valid = o_valid_q;
  assign o_pkt_data       = o_data_q;
  assign o_pkt_len        = o_len_q;
  assign o_pkt_num        = o_num_q;
  assign o_pkt_protocol   = o_proto_q;
  assign o_pkt_cycle_cnt  = o_cyc_q;
  assign o_flow_id        = o_fid_q;
  assign o_flow_type      = o_type_q;
  assign o_decide         = o_dec_q;
  assign o_match_cnt      = cnt_q;
endmodule

// File: tb/tb_ssh_banner_classify.sv
// tb_ssh_banner_classify: directed vector table plus clear, back-to-back and reset sequences
module tb_ssh_banner_classify;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_valid = 1'b0;
  logic [63:0] i_data = '0;
  logic [7:0]  i_len = 8'd60;
  logic [2:0]  i_num = '0;
  logic [7:0]  i_proto = '0;
  logic [5:0]  i_cyc = '0;
  logic [7:0]  i_fid = '0;
  logic        i_clr = 1'b0;
  logic [7:0]  i_clr_id = '0;
  logic        o_valid;
  logic [63:0] o_data;
  logic [7:0]  o_len;
  logic [2:0]  o_num;
  logic [7:0]  o_proto;
  logic [5:0]  o_cyc;
  logic [7:0]  o_fid;
  logic [2:0]  o_type;
  logic        o_dec;
  logic [15:0] o_cnt;
  int total = 0;
  int bad = 0;
  int ecnt = 0;
  localparam logic [63:0] B = 64'h2d302e32_2d485353;
  localparam logic [63:0] OLD = 64'h2d392e31_2d485353;
`ifdef SSH_VER_CHECK_EN
  localparam logic OLD_OK = 1'b0;
`else
  localparam logic OLD_OK = 1'b1;
`endif
  typedef struct {
    logic        v;
    logic [63:0] d;
    logic [2:0]  num;
    logic [7:0]  pr;
    logic [5:0]  cy;
    logic [7:0]  fid;
    logic [2:0]  et;
    logic        ed;
    logic        m;
  } vec_t;
  vec_t vt [12];
  ssh_banner_classify dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_pkt_data_valid(i_valid), .i_pkt_data(i_data), .i_pkt_len(i_len),
    .i_pkt_num(i_num), .i_pkt_protocol(i_proto), .i_pkt_cycle_cnt(i_cyc),
    .i_flow_id(i_fid), .i_flow_clr(i_clr), .i_flow_clr_id(i_clr_id),
    .o_pkt_data_valid(o_valid), .o_pkt_data(o_data), .o_pkt_len(o_len),
    .o_pkt_num(o_num), .o_pkt_protocol(o_proto), .o_pkt_cycle_cnt(o_cyc),
    .o_flow_id(o_fid), .o_flow_type(o_type), .o_decide(o_dec), .o_match_cnt(o_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", n, a, e);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v, input logic [63:0] d, input logic [2:0] num,
                       input logic [7:0] pr, input logic [5:0] cy, input logic [7:0] fid);
    i_valid = v;
    i_data = d;
    i_num = num;
    i_proto = pr;
    i_cyc = cy;
    i_fid = fid;
  endtask
  task automatic idle();
    drive(1'b0, 64'd0, 3'd0, 8'd0, 6'd0, 8'd0);
  endtask
  task automatic beat_check(input string n, input logic [7:0] fid, input logic [63:0] d,
                            input logic [2:0] t);
    chk({n, "_valid"}, o_valid, 1);
    chk({n, "_fid"}, o_fid, fid);
    chk({n, "_data"}, o_data, d);
    chk({n, "_type"}, o_type, t);
    chk({n, "_cnt"}, o_cnt, ecnt);
  endtask
  initial begin
    vt[0]  = '{1'b1, B,         3'd0, 8'h06, 6'd1,  8'd5,  3'b100, 1'b0, 1'b1};
    vt[1]  = '{1'b1, 64'h1234,  3'd0, 8'h06, 6'd2,  8'd5,  3'b100, 1'b0, 1'b0};
    vt[2]  = '{1'b1, B,         3'd0, 8'h11, 6'd1,  8'd7,  3'b000, 1'b0, 1'b0};
    vt[3]  = '{1'b0, B,         3'd0, 8'h06, 6'd1,  8'd7,  3'b000, 1'b0, 1'b0};
    vt[4]  = '{1'b1, 64'h55,    3'd4, 8'h06, 6'd32, 8'd9,  3'b000, 1'b1, 1'b0};
    vt[5]  = '{1'b1, B,         3'd0, 8'h06, 6'd1,  8'd9,  3'b000, 1'b0, 1'b0};
    vt[6]  = '{1'b1, 64'h66,    3'd4, 8'h06, 6'd32, 8'd5,  3'b100, 1'b1, 1'b0};
    vt[7]  = '{1'b1, B,         3'd0, 8'h06, 6'd1,  8'd5,  3'b100, 1'b0, 1'b0};
    vt[8]  = '{1'b1, OLD,       3'd0, 8'h06, 6'd1,  8'd12, OLD_OK ? 3'b100 : 3'b000, 1'b0, OLD_OK};
    vt[9]  = '{1'b1, B,         3'd0, 8'h06, 6'd1,  8'd13, 3'b100, 1'b0, 1'b1};
    vt[10] = '{1'b1, B,         3'd0, 8'h06, 6'd0,  8'd14, 3'b000, 1'b0, 1'b0};
    vt[11] = '{1'b0, 64'h77,    3'd4, 8'h06, 6'd32, 8'd15, 3'b000, 1'b0, 1'b0};
    idle();
    #12;
    chk("rst_valid", o_valid, 0);
    chk("rst_type", o_type, 0);
    chk("rst_decide", o_dec, 0);
    chk("rst_cnt", o_cnt, 0);
    tick();
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 12; i++) begin
      drive(vt[i].v, vt[i].d, vt[i].num, vt[i].pr, vt[i].cy, vt[i].fid);
      tick();
      idle();
      tick();
      if (vt[i].m) ecnt++;
      chk($sformatf("v%0d_valid", i), o_valid, vt[i].v);
      chk($sformatf("v%0d_data", i), o_data, vt[i].d);
      chk($sformatf("v%0d_fid", i), o_fid, vt[i].fid);
      chk($sformatf("v%0d_proto", i), o_proto, vt[i].pr);
      chk($sformatf("v%0d_cyc", i), o_cyc, vt[i].cy);
      chk($sformatf("v%0d_num", i), o_num, vt[i].num);
      chk($sformatf("v%0d_len", i), o_len, 8'd60);
      chk($sformatf("v%0d_type", i), o_type, vt[i].et);
      chk($sformatf("v%0d_decide", i), o_dec, vt[i].ed);
      chk($sformatf("v%0d_cnt", i), o_cnt, ecnt);
    end
    drive(1'b1, B, 3'd0, 8'h06, 6'd1, 8'd20);
    tick();
    drive(1'b1, 64'h99, 3'd0, 8'h06, 6'd2, 8'd20);
    tick();
    idle();
    ecnt++;
    beat_check("b2b_first", 8'd20, B, 3'b100);
    tick();
    beat_check("b2b_second", 8'd20, 64'h99, 3'b100);
    i_clr = 1'b1;
    i_clr_id = 8'd5;
    tick();
    i_clr = 1'b0;
    drive(1'b1, 64'h2, 3'd0, 8'h06, 6'd2, 8'd5);
    tick();
    idle();
    tick();
    beat_check("clr_alone", 8'd5, 64'h2, 3'b000);
    drive(1'b1, B, 3'd0, 8'h06, 6'd1, 8'd5);
    tick();
    idle();
    i_clr = 1'b1;
    i_clr_id = 8'd5;
    tick();
    i_clr = 1'b0;
    ecnt++;
    beat_check("clr_same_match", 8'd5, B, 3'b100);
    drive(1'b1, 64'h3, 3'd0, 8'h06, 6'd2, 8'd5);
    tick();
    idle();
    tick();
    beat_check("clr_same_after", 8'd5, 64'h3, 3'b100);
    drive(1'b1, B, 3'd0, 8'h06, 6'd1, 8'd21);
    tick();
    idle();
    i_clr = 1'b1;
    i_clr_id = 8'd13;
    tick();
    i_clr = 1'b0;
    ecnt++;
    beat_check("clr_diff_match", 8'd21, B, 3'b100);
    drive(1'b1, 64'h4, 3'd0, 8'h06, 6'd2, 8'd13);
    tick();
    drive(1'b1, 64'h5, 3'd0, 8'h06, 6'd2, 8'd21);
    tick();
    idle();
    beat_check("clr_diff_13", 8'd13, 64'h4, 3'b000);
    tick();
    beat_check("clr_diff_21", 8'd21, 64'h5, 3'b100);
    drive(1'b1, 64'h6, 3'd0, 8'h06, 6'd2, 8'd5);
    tick();
    drive(1'b1, 64'h7, 3'd0, 8'h06, 6'd3, 8'd5);
    tick();
    beat_check("pre_rst", 8'd5, 64'h6, 3'b100);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", o_valid, 0);
    chk("arst_type", o_type, 0);
    chk("arst_data", o_data, 0);
    chk("arst_cnt", o_cnt, 0);
    chk("arst_fid", o_fid, 0);
    idle();
    tick();
    chk("arst_hold_valid", o_valid, 0);
    rst_n = 1'b1;
    ecnt = 0;
    tick();
    drive(1'b1, 64'h8, 3'd0, 8'h06, 6'd2, 8'd5);
    tick();
    idle();
    tick();
    beat_check("post_rst", 8'd5, 64'h8, 3'b000);
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
